alu_iter: RTL and testbench

Parametrised successor to the single-cycle RV32I ALU. It keeps the base ALU opcode set and adds iterative multiply/divide operations (RV M-extension semantics) behind a valid/ready handshake. It sits in the execute stage. Base ops complete in one cycle; M ops stall the pipe through `in_ready` for XLEN cycles. Results are registered and held until consumed.

---
 rtl/alu_iter_if.sv | 25 ++
 rtl/alu_iter.sv | 159 +++++++++++++++
 tb/tb_alu_iter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_iter_if.sv
// rtl/alu_iter_if.sv - request/result handshake bundle for the iterative RV32I/M ALU
interface alu_iter_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            op_md;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op_md, op, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op_md, op, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - execute-stage ALU: single-cycle base ops, iterative mul/div behind valid/ready
// Multiply/divide support is compiled only when ALU_ITER_MDU_EN is defined.
module alu_iter #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_iter_if.slave  bus
);
    localparam int SW = $clog2(XLEN);

`ifdef ALU_ITER_MDU_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, OUT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, OUT = 2'd2} state_t;
`endif

    state_t          state;
    logic [XLEN-1:0] res_q;
    logic            out_valid_q;
    logic            accept;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] base_res;
    logic [XLEN-1:0] spec_res;

    assign bus.in_ready  = (state == IDLE) || (state == OUT && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign shamt         = bus.b[SW-1:0];

    always_comb begin
        base_res = '0;
        case (bus.op)
            4'b0000: base_res = bus.a + bus.b;
            4'b1000: base_res = bus.a - bus.b;
            4'b0100: base_res = bus.a ^ bus.b;
            4'b0110: base_res = bus.a | bus.b;
            4'b0111: base_res = bus.a & bus.b;
            4'b0001: base_res = bus.a << shamt;
            4'b0101: base_res = bus.a >> shamt;
            4'b1101: base_res = $unsigned($signed(bus.a) >>> shamt);
            4'b0010: base_res = XLEN'($signed(bus.a) < $signed(bus.b));
            4'b0011: base_res = XLEN'(bus.a < bus.b);
            default: base_res = '0;
        endcase
    end

`ifdef ALU_ITER_MDU_EN
    localparam logic [SW-1:0]   CNT_TOP = SW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_S   = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      f3_in, f3_q;
    logic            a_neg, b_neg, is_div, div_zero, div_ovf, special, neg_d, neg_q, busy_q;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] hi, lo, opnd, hi_n, lo_n, fin;
    logic [XLEN:0]   sum, shl, dif;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [SW-1:0]   cnt;

    assign bus.busy = busy_q;

    // Operand conditioning: signedness per funct3, magnitudes, and one-cycle divide corners.
    always_comb begin
        f3_in    = bus.op[2:0];
        is_div   = f3_in[2];
        a_neg    = bus.a[XLEN-1] && (f3_in == 3'b001 || f3_in == 3'b010 ||
                                     f3_in == 3'b100 || f3_in == 3'b110);
        b_neg    = bus.b[XLEN-1] && (f3_in == 3'b001 || f3_in == 3'b100 || f3_in == 3'b110);
        a_mag    = a_neg ? -bus.a : bus.a;
        b_mag    = b_neg ? -bus.b : bus.b;
        neg_d    = (is_div && f3_in[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div && (bus.b == '0);
        div_ovf  = is_div && !f3_in[0] && (bus.a == MIN_S) && (bus.b == '1);
        special  = div_zero || div_ovf;
        spec_res = '0;
        if (div_zero)
            spec_res = f3_in[1] ? bus.a : '1;
        else if (div_ovf)
            spec_res = f3_in[1] ? '0 : bus.a;
    end

    // hi/lo serve as product accumulator for multiply and remainder/quotient for divide.
    always_comb begin
        sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shl = {hi, lo[XLEN-1]};
        dif = shl - {1'b0, opnd};
        if (f3_q[2]) begin
            hi_n = dif[XLEN] ? shl[XLEN-1:0] : dif[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], ~dif[XLEN]};
        end else begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo[XLEN-1:1]};
        end
        prod   = {hi_n, lo_n};
        prod_s = neg_q ? -prod : prod;
        case (f3_q)
            3'b000:                 fin = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin = neg_q ? -lo_n : lo_n;
            default:                fin = neg_q ? -hi_n : hi_n;
        endcase
    end
`else
    assign spec_res = '0;
    assign bus.busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
`ifdef ALU_ITER_MDU_EN
            busy_q <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            f3_q   <= '0;
`endif
        end else if (accept) begin
`ifdef ALU_ITER_MDU_EN
            if (bus.op_md && !special) begin
                state       <= CALC;
                busy_q      <= 1'b1;
                out_valid_q <= 1'b0;
                cnt         <= CNT_TOP;
                hi          <= '0;
                lo          <= is_div ? a_mag : b_mag;
                opnd        <= is_div ? b_mag : a_mag;
                neg_q       <= neg_d;
                f3_q        <= f3_in;
            end else
`endif
            begin
                state       <= OUT;
                out_valid_q <= 1'b1;
                res_q       <= bus.op_md ? spec_res : base_res;
            end
        end else if (state == OUT && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
`ifdef ALU_ITER_MDU_EN
        end else if (state == CALC) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                state       <= OUT;
                busy_q      <= 1'b0;
                out_valid_q <= 1'b1;
                res_q       <= fin;
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - directed-vector bench for alu_iter (expectations follow ALU_ITER_MDU_EN)
module tb_alu_iter;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errs    = 0;

`ifdef ALU_ITER_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif
    localparam int ML = MDU ? 32 : 0;

    alu_iter_if #(.XLEN(32)) bus ();

    alu_iter #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mres(input logic [31:0] v);
        return MDU ? v : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic md, input logic [3:0] code,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp, input int exp_lat);
        int   lat;
        int   guard;
        logic rdy_seen;
        logic busy_bad;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            tick();
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.op_md    = md;
        bus.op       = code;
        bus.a        = av;
        bus.b        = bv;
        tick();
        bus.in_valid = 1'b0;
        bus.op       = ~code;
        bus.a        = ~av;
        bus.b        = ~bv;
        lat      = 0;
        rdy_seen = 1'b0;
        busy_bad = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            if (bus.busy !== 1'b1) busy_bad = 1'b1;
            tick();
            lat++;
        end
        check({tag, " result"}, 64'(bus.result), 64'(exp));
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        if (exp_lat > 0) begin
            check({tag, " in_ready low in CALC"}, 64'(rdy_seen), 64'(0));
            check({tag, " busy high in CALC"}, 64'(busy_bad), 64'(0));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int   seen;
        logic held_bad;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_md     = 1'b0;
        bus.op        = 4'h0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("reset out_valid", 64'(bus.out_valid), 64'(0));
        check("reset result", 64'(bus.result), 64'(0));
        check("reset in_ready", 64'(bus.in_ready), 64'(1));
        check("reset busy", 64'(bus.busy), 64'(0));
        rst_n = 1'b1;
        tick();

        run_op("ADD 5+7", 1'b0, 4'b0000, 32'd5, 32'd7, 32'd12, 0);
        run_op("SUB 5-7", 1'b0, 4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE, 0);
        run_op("SLT", 1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
        run_op("SLTU", 1'b0, 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
        run_op("SRA 4", 1'b0, 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, 0);
        run_op("SRA 36", 1'b0, 4'b1101, 32'h8000_0000, 32'd36, 32'hF800_0000, 0);
        run_op("SRL 4", 1'b0, 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 0);
        run_op("SLL 31", 1'b0, 4'b0001, 32'd1, 32'd31, 32'h8000_0000, 0);
        run_op("XOR", 1'b0, 4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 0);
        run_op("OR", 1'b0, 4'b0110, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 0);
        run_op("AND", 1'b0, 4'b0111, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0);
        run_op("bad code", 1'b0, 4'b1111, 32'h1234, 32'h5678, 32'h0, 0);

        run_op("MULH", 1'b1, 4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mres(32'h0), ML);
        run_op("MULHU", 1'b1, 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mres(32'hFFFF_FFFE), ML);
        run_op("MUL 7x-3", 1'b1, 4'b1000, 32'd7, 32'hFFFF_FFFD, mres(32'hFFFF_FFEB), ML);
        run_op("MULHSU", 1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd2, mres(32'hFFFF_FFFF), ML);
        run_op("DIV -7/2", 1'b1, 4'b0100, 32'hFFFF_FFF9, 32'd2, mres(32'hFFFF_FFFD), ML);
        run_op("REM -7/2", 1'b1, 4'b0110, 32'hFFFF_FFF9, 32'd2, mres(32'hFFFF_FFFF), ML);
        run_op("DIVU 100/7", 1'b1, 4'b0101, 32'd100, 32'd7, mres(32'd14), ML);
        run_op("REMU 100/7", 1'b1, 4'b0111, 32'd100, 32'd7, mres(32'd2), ML);
        run_op("DIVU x/0", 1'b1, 4'b0101, 32'h1234, 32'd0, mres(32'hFFFF_FFFF), 0);
        run_op("REM 9/0", 1'b1, 4'b0110, 32'd9, 32'd0, mres(32'd9), 0);
        run_op("DIV ovf", 1'b1, 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, mres(32'h8000_0000), 0);
        run_op("REM ovf", 1'b1, 4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, mres(32'h0), 0);

        // Backpressure: hold result for 5 cycles, then three back-to-back ADDs.
        bus.in_valid = 1'b1;
        bus.op_md    = 1'b0;
        bus.op       = 4'b0000;
        bus.a        = 32'd1;
        bus.b        = 32'd2;
        tick();
        bus.in_valid = 1'b0;
        held_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.result !== 32'd3 || bus.in_ready !== 1'b0)
                held_bad = 1'b1;
            tick();
        end
        check("backpressure hold", 64'(held_bad), 64'(0));
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.a = 32'(10 * i);
            bus.b = 32'(i);
            tick();
            check($sformatf("b2b add %0d valid", i), 64'(bus.out_valid), 64'(1));
            check($sformatf("b2b add %0d result", i), 64'(bus.result), 64'(11 * i));
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        check("drain out_valid", 64'(bus.out_valid), 64'(0));

        // Reset at cycle 10 of an iterative DIVU.
        bus.in_valid = 1'b1;
        bus.op_md    = 1'b1;
        bus.op       = 4'b0101;
        bus.a        = 32'd1000;
        bus.b        = 32'd3;
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check("midcalc rst out_valid", 64'(bus.out_valid), 64'(0));
        check("midcalc rst busy", 64'(bus.busy), 64'(0));
        check("midcalc rst in_ready", 64'(bus.in_ready), 64'(1));
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            if (bus.out_valid) seen++;
            tick();
        end
        check("aborted op silent", 64'(seen), 64'(0));
        run_op("DIVU after rst", 1'b1, 4'b0101, 32'd1000, 32'd3, mres(32'd333), ML);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
